// File: rtl/smm_pkg.sv
// Shared definitions for the single-level Strassen multiplier family:
// element width default, matrix element count, bus width helper and the
// operand loader state encoding.
package smm_pkg;

    localparam int DATAWIDTH_DEFAULT = 32;
    localparam int ELEMS = 16;

    // Width of one packed 4x4 operand bus for a given element width.
    function automatic int bus_width(input int dw);
        return ELEMS * dw;
    endfunction

    localparam int BUSWIDTH = bus_width(DATAWIDTH_DEFAULT);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ISSUE   = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/smm_operand_loader_if.sv
// Element stream in, packed operand buses out. The master side is the
// element source that also observes the operand buses; the slave side is
// the loader itself.
interface smm_operand_loader_if #(
    parameter int DATAWIDTH = smm_pkg::DATAWIDTH_DEFAULT
);
    logic [DATAWIDTH-1:0]                      s_data;
    logic                                      s_valid;
    logic                                      s_ready;
    logic                                      cfg_sel;
    logic [smm_pkg::bus_width(DATAWIDTH)-1:0]  A;
    logic [smm_pkg::bus_width(DATAWIDTH)-1:0]  B;
    logic                                      load;
    logic                                      sel;

    modport master (
        output s_data, s_valid, cfg_sel,
        input  s_ready, A, B, load, sel
    );

    modport slave (
        input  s_data, s_valid, cfg_sel,
        output s_ready, A, B, load, sel
    );
endinterface

// File: rtl/smm_hold_timer.sv
// Loadable down-counter. Loaded on start, counts down to zero and flags
// the last counted cycle so the owner can leave its hold state on time.
module smm_hold_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count_reg;

    // Load on start, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (start) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    // A count of one means this is the final hold cycle.
    assign expired = (count_reg == WIDTH'(1));

endmodule

// File: rtl/smm_operand_loader.sv
// Packs a 32-element stream (A then B, row-major) into the multiplier's two
// 4x4 operand buses, strobes load for one cycle, then refuses input while
// the multiplier's load pipeline captures the held operands.
module smm_operand_loader
    import smm_pkg::*;
#(
    parameter int DATAWIDTH   = DATAWIDTH_DEFAULT,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    smm_operand_loader_if.slave   bus,
    output logic                  busy,
    output logic [15:0]           frame_count
);

    localparam logic [4:0] LAST_IDX = 5'd31;

    state_t                state_reg;
    state_t                state_next;
    logic [4:0]            idx_reg;
    logic [DATAWIDTH-1:0]  a_slot_reg [ELEMS];
    logic [DATAWIDTH-1:0]  b_slot_reg [ELEMS];
    logic                  sel_reg;
    logic [15:0]           frame_count_reg;

    logic                  s_ready_int;
    logic                  handshake;
    logic                  load_next;
    logic                  timer_start;
    logic                  hold_expired;

    // Ready is forced low while reset is held so nothing is accepted then.
    assign s_ready_int = (state_reg == COLLECT) && rst_n;
    assign handshake   = bus.s_valid && s_ready_int;

    smm_hold_timer #(
        .WIDTH (4)
    ) u_hold_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (timer_start),
        .load_value (4'(HOLD_CYCLES)),
        .expired    (hold_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_next  = state_reg;
        load_next   = 1'b0;
        timer_start = 1'b0;
        case (state_reg)
            COLLECT: begin
                if (handshake && (idx_reg == LAST_IDX)) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                load_next   = 1'b1;
                timer_start = 1'b1;
                state_next  = HOLD;
            end
            HOLD: begin
                if (hold_expired) begin
                    state_next = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    // Element index; wraps 31 -> 0 so the next frame starts at slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg <= '0;
        end else if (handshake) begin
            idx_reg <= idx_reg + 5'd1;
        end
    end

    // Operand slot storage: first 16 elements to A, next 16 to B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ELEMS; i++) begin
                a_slot_reg[i] <= '0;
                b_slot_reg[i] <= '0;
            end
        end else if (handshake) begin
            if (!idx_reg[4]) begin
                a_slot_reg[idx_reg[3:0]] <= bus.s_data;
            end else begin
                b_slot_reg[idx_reg[3:0]] <= bus.s_data;
            end
        end
    end

    // Mode is latched only with the first element of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg <= 1'b0;
        end else if (handshake && (idx_reg == 5'd0)) begin
            sel_reg <= bus.cfg_sel;
        end
    end

    // Issued-frame counter, advanced by the ISSUE cycle and free to wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_reg <= '0;
        end else if (state_reg == ISSUE) begin
            frame_count_reg <= frame_count_reg + 16'd1;
        end
    end

    // Slot (r,c) lands at bits [(4r+c)*DATAWIDTH +: DATAWIDTH]; row 0 lowest.
    for (genvar gi = 0; gi < ELEMS; gi++) begin : g_pack
        assign bus.A[gi*DATAWIDTH +: DATAWIDTH] = a_slot_reg[gi];
        assign bus.B[gi*DATAWIDTH +: DATAWIDTH] = b_slot_reg[gi];
    end

    assign bus.s_ready  = s_ready_int;
    assign bus.load     = load_next;
    assign bus.sel      = sel_reg;
    assign busy         = (state_reg != COLLECT);
    assign frame_count  = frame_count_reg;

endmodule

// File: tb/tb_smm_operand_loader.sv
// Directed bench for smm_operand_loader. The driver pushes the expected
// operand frame into a queue before streaming it; an independent monitor
// pops and compares whenever load is seen, and also watches HOLD behaviour.
module tb_smm_operand_loader;
    import smm_pkg::*;

    localparam int DW   = 32;
    localparam int HOLD = 4;
    localparam int BW   = 16 * DW;

    typedef struct {
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic          sel;
        logic [15:0]   fc;
        int            span;
        int            gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [15:0] frame_count;

    smm_operand_loader_if #(.DATAWIDTH(DW)) bus();

    smm_operand_loader #(
        .DATAWIDTH   (DW),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    logic [15:0] exp_fc = 16'd0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    exp_t cur;
    bit   have_cur = 0;
    int   hs_idx = 0, first_hs = 0, last_hs = 0, prev_last = -1, frame_gap = -1, busy_run = 0;
    bit   fc_pend = 0, sel_pend = 0;
    logic sel_exp_v = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hs_idx = 0; prev_last = -1; frame_gap = -1; busy_run = 0;
            fc_pend = 0; sel_pend = 0; have_cur = 0;
        end else begin
            if (sel_pend) begin
                chk("sel_after_idx0", BW'(bus.sel), BW'(sel_exp_v));
                sel_pend = 0;
            end
            if (fc_pend) begin
                chk("frame_count", BW'(frame_count), BW'(cur.fc));
                fc_pend = 0;
            end
            if (bus.load) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_load: load=1 at cycle %0d, required no load", cyc);
                end else begin
                    cur = q.pop_front();
                    have_cur = 1;
                    $display("load cycle=%0d sel=%0b A[0]=%08h A[15]=%08h B[0]=%08h exp_fc=%04h",
                             cyc, bus.sel, bus.A[31:0], bus.A[511:480], bus.B[31:0], cur.fc);
                    chk("A_bus", bus.A, cur.a);
                    chk("B_bus", bus.B, cur.b);
                    chk("sel_at_load", BW'(bus.sel), BW'(cur.sel));
                    chk("load_latency", BW'(cyc - last_hs), BW'(1));
                    chk("frame_span", BW'(last_hs - first_hs), BW'(cur.span));
                    if (cur.gap >= 0) chk("hold_gap", BW'(frame_gap), BW'(cur.gap));
                    fc_pend = 1;
                end
            end
            if (busy) begin
                busy_run++;
                chk("ready_low_while_busy", BW'(bus.s_ready), BW'(0));
                if (!bus.load && have_cur) begin
                    chk("A_held", bus.A, cur.a);
                    chk("B_held", bus.B, cur.b);
                    chk("sel_held", BW'(bus.sel), BW'(cur.sel));
                end
            end else if (busy_run != 0) begin
                chk("busy_cycles", BW'(busy_run), BW'(1 + HOLD));
                busy_run = 0;
            end
            if (bus.s_valid && bus.s_ready) begin
                if (hs_idx == 0) begin
                    first_hs  = cyc;
                    frame_gap = (prev_last >= 0) ? (cyc - prev_last) : -1;
                    sel_pend  = 1;
                    sel_exp_v = bus.cfg_sel;
                end
                if (hs_idx == 31) begin
                    last_hs   = cyc;
                    prev_last = cyc;
                end
                hs_idx = (hs_idx == 31) ? 0 : hs_idx + 1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send_elem(input logic [DW-1:0] d, input logic cs, input bit gap);
        int t = 0;
        bus.s_data  = d;
        bus.cfg_sel = cs;
        bus.s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.s_ready) break;
            t++;
            if (t > 200) begin
                checks++; errors++;
                $display("FAIL handshake_timeout: s_ready=%0b for 200 cycles, required 1", bus.s_ready);
                break;
            end
        end
        @(posedge clk); #1;
        if (gap) begin
            bus.s_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [BW-1:0] a, input logic [BW-1:0] b,
                              input logic sel0, input logic sel_rest, input bit gap,
                              input int span, input int gap_exp, input int n);
        exp_t e;
        if (n == 32) begin
            exp_fc = exp_fc + 16'd1;
            e.a = a; e.b = b; e.sel = sel0; e.fc = exp_fc; e.span = span; e.gap = gap_exp;
            q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] d;
            d = (i < 16) ? a[i*DW +: DW] : b[(i-16)*DW +: DW];
            send_elem(d, (i == 0) ? sel0 : sel_rest, gap);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(q.size() == 0 && !busy && bus.s_ready)) begin
            @(negedge clk);
            t++;
            if (t > 300) begin
                checks++; errors++;
                $display("FAIL idle_timeout: busy=%0b pending=%0d, required idle", busy, q.size());
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_values();
        chk("rst_A", bus.A, '0);
        chk("rst_B", bus.B, '0);
        chk("rst_load", BW'(bus.load), BW'(0));
        chk("rst_sel", BW'(bus.sel), BW'(0));
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_frame_count", BW'(frame_count), BW'(0));
        chk("rst_s_ready", BW'(bus.s_ready), BW'(0));
    endtask

    logic [BW-1:0] a_v, b_v;

    initial begin
        bus.s_data = '0; bus.s_valid = 1'b0; bus.cfg_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", BW'(bus.s_ready), BW'(1));

        // Frame 1: A=i+1, B=0x100+i, sel 0, continuous valid.
        for (int i = 0; i < 16; i++) begin
            a_v[i*DW +: DW] = DW'(i + 1);
            b_v[i*DW +: DW] = DW'(32'h100 + i);
        end
        send_frame(a_v, b_v, 1'b0, 1'b0, 1'b0, 31, -1, 32);
        // Frame 2: same data, valid toggling; starts while frame 1 is held.
        send_frame(a_v, b_v, 1'b0, 1'b0, 1'b1, 62, 6, 32);

        // Frame 3: negative/sign-bit data, sel 1.
        for (int i = 0; i < 16; i++) begin
            a_v[i*DW +: DW] = 32'hFFFF_FF00 + DW'(i);
            b_v[i*DW +: DW] = 32'h8000_0000 | DW'(i);
        end
        send_frame(a_v, b_v, 1'b1, 1'b1, 1'b0, 31, 6, 32);
        // Frame 4: sel 0 at idx 0 only; element 0 differs from held A[0].
        for (int i = 0; i < 16; i++) begin
            a_v[i*DW +: DW] = DW'(i) * 32'h0101_0101;
            b_v[i*DW +: DW] = 32'hFFFF_FFFF ^ DW'(i);
        end
        send_frame(a_v, b_v, 1'b0, 1'b1, 1'b0, 31, 6, 32);
        wait_idle();

        // Partial frame, then asynchronous reset after 20 handshakes.
        for (int i = 0; i < 16; i++) begin
            a_v[i*DW +: DW] = 32'h5555_0000 + DW'(i);
            b_v[i*DW +: DW] = 32'h6666_0000 + DW'(i);
        end
        send_frame(a_v, b_v, 1'b1, 1'b1, 1'b0, 31, -1, 20);
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        exp_fc = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fresh full frame after reset.
        for (int i = 0; i < 16; i++) begin
            a_v[i*DW +: DW] = 32'h7FFF_FFFF - DW'(i);
            b_v[i*DW +: DW] = DW'(i) << 4;
        end
        send_frame(a_v, b_v, 1'b1, 1'b1, 1'b0, 31, -1, 32);
        bus.s_valid = 1'b0;
        wait_idle();

        // Counter wrap: preset to 0xFFFF while idle, next ISSUE gives 0.
        force dut.frame_count_reg = 16'hFFFF;
        @(posedge clk); #1;
        release dut.frame_count_reg;
        @(posedge clk); #1;
        chk("frame_count_preset", BW'(frame_count), BW'(16'hFFFF));
        exp_fc = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            a_v[i*DW +: DW] = DW'(i) * 32'd3;
            b_v[i*DW +: DW] = 32'hDEAD_0000 + DW'(i);
        end
        send_frame(a_v, b_v, 1'b0, 1'b0, 1'b0, 31, -1, 32);
        bus.s_valid = 1'b0;
        wait_idle();

        chk("scoreboard_drained", BW'(q.size()), BW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/smm_operand_loader.md
# smm_operand_loader

Upstream feeder for the single-level Strassen matrix multiplier (`SMM1`). It accepts a stream of 32 signed elements over a valid/ready handshake: 16 of matrix A, then 16 of matrix B, each row-major. It packs them into the two 4x4 operand buses in the multiplier's bus layout, issues a single-cycle `load` strobe, then holds the operands stable until the multiplier's internal load pipeline has captured them.

## Interface
Parameters:
- `DATAWIDTH`, 32, element width in bits.
- `HOLD_CYCLES`, 4, cycles operands are held after `load` before the next frame is accepted (1..15).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `s_data` in DATAWIDTH: signed input element.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: loader accepts an element this cycle.
- `cfg_sel` in 1: reduced-mode select, sampled with element 0 of each frame.
- `A` out 16*DATAWIDTH: packed matrix A.
- `B` out 16*DATAWIDTH: packed matrix B.
- `load` out 1: one-cycle operand-valid strobe to the multiplier.
- `sel` out 1: latched mode for the current frame.
- `busy` out 1: high in ISSUE and HOLD.
- `frame_count` out 16: frames issued, wraps modulo 2^16.

## Operation
- Element (r,c) of a matrix occupies bits `[(4r+c)*DATAWIDTH +: DATAWIDTH]` of its bus. Row 0 is in the lowest bits. This matches the multiplier's 2x2 block extraction.
- A handshake occurs on a cycle where `s_valid && s_ready`. Only handshake cycles advance the index `idx` (0..31).
- For idx 0..15, the element is written to the A slot `idx`. For idx 16..31, it is written to the B slot `idx-16`. No other slot changes.
- On the handshake at idx 0, `cfg_sel` is captured into `sel`. `sel` changes at no other time.
- States:
  - COLLECT: `s_ready`=1. On the handshake at idx 31, go to ISSUE.
  - ISSUE: lasts exactly 1 cycle. `load`=1, `s_ready`=0, `frame_count` increments. Then go to HOLD.
  - HOLD: `load`=0, `s_ready`=0, lasts HOLD_CYCLES cycles. Then go to COLLECT with idx=0.
- `A` and `B` are not cleared between frames. Slots keep their previous frame's values until overwritten. The multiplier must sample only on `load`.
- No arithmetic is performed on the data. Elements are stored bit-exact. `frame_count` wraps 0xFFFF to 0x0000.

## Timing
- Reset values: `A`=0, `B`=0, `load`=0, `sel`=0, `busy`=0, `frame_count`=0, `s_ready`=0 while `rst_n` is low.
- First cycle after reset release: COLLECT, `s_ready`=1, idx=0.
- `load` is asserted in the cycle immediately after the idx-31 handshake. `A` and `B` are complete and registered in that same cycle.
- `A`, `B` and `sel` are constant from the ISSUE cycle through the last HOLD cycle.
- Back-to-back throughput: 32 + 1 + HOLD_CYCLES cycles per frame with continuous `s_valid`.
- `s_valid` low in COLLECT stalls with no state change. Gaps of any length are legal.
- `s_valid` while `s_ready`=0 is ignored. The source must hold its data until a handshake.
- Reset asserted mid-frame or mid-HOLD:
  - All outputs return immediately (asynchronously) to their reset values.
  - The partial frame is discarded and no `load` is issued.

## Structure
- Shared package `smm_pkg` holds:
  - `DATAWIDTH` default and `ELEMS`=16.
  - The bus-width function `BUSWIDTH = 16*DATAWIDTH`.
  - The state enum {COLLECT, ISSUE, HOLD}.
- The multiplier blocks reuse these from `smm_pkg`.
- One natural sub-module: `smm_hold_timer`, a loadable down-counter that is started on ISSUE and reports expiry. Everything else stays flat.

## Test plan
- Reset, then stream A[i]=i+1 and B[i]=0x100+i with `cfg_sel`=0 and continuous valid:
  - `load` is high exactly once, at cycle 33 after the first handshake.
  - `A[31:0]`=1, `A[511:480]`=16, `B[31:0]`=0x100.
  - `sel`=0 and `frame_count`=1.
- Same stream with `s_valid` toggling every other cycle -> identical buses; `load` arrives after 64 cycles.
- Frame 1 with `cfg_sel`=1, frame 2 with `cfg_sel`=0 at idx 0 (and `cfg_sel`=1 at other indices):
  - `sel`=1 through frame-1 HOLD.
  - `sel`=0 from the frame-2 idx-0 handshake onward.
- Drive valid continuously during HOLD with HOLD_CYCLES=4:
  - `s_ready`=0 for 5 cycles (ISSUE + 4 HOLD).
  - No slot changes.
  - The next handshake occurs in the 6th cycle after the idx-31 handshake.
- Assert `rst_n` low after 20 handshakes:
  - Buses read 0 immediately and no `load` is issued.
  - After release, a full new frame issues `load` and `frame_count`=1.
- Issue 65536 frames (or force the counter to 0xFFFF) -> `frame_count` wraps to 0 on the next ISSUE.
